// File: rtl/game_sequencer.sv
// Move/load initiator for the score counter: queues moves, seeds games, reports results.
// Optional `AUTO_RESTART_EN: DONE reloads the last seed and replays instead of idling.
module game_sequencer #(
  parameter int SIZE       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAMES_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               start_valid,
  input  logic [SIZE-1:0]    start_seed,
  output logic               INIT_c,
  output logic [SIZE-1:0]    INIT_l,
  output logic [1:0]         control,
  input  logic               GAMEOVER,
  input  logic [1:0]         WHO,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         result_who,
  output logic [GAMES_W-1:0] games_played
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t              state, state_d;
  logic [1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_d;
  logic [SIZE-1:0]     shadow, shadow_d, last_seed;
  logic                push, pop, flush;
  logic                init_c_d, busy_d, result_valid_d, cmd_ready_d;
  logic [SIZE-1:0]     init_l_d;
  logic [1:0]          control_d, result_who_d, head;
  logic [GAMES_W-1:0]  games_d;

  // Same step sizes the counter applies, wrapping modulo 2^SIZE.
  function automatic logic [SIZE-1:0] step_of(input logic [1:0] op);
    case (op)
      2'b00:   step_of = SIZE'(1);
      2'b01:   step_of = SIZE'(2);
      2'b10:   step_of = {SIZE{1'b1}};
      default: step_of = ~SIZE'(1);
    endcase
  endfunction

  assign head = mem[rd_ptr];
  assign push = cmd_valid & cmd_ready & (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d        = state;
    shadow_d       = shadow;
    init_c_d       = 1'b1;
    init_l_d       = shadow;
    control_d      = control;
    result_valid_d = 1'b0;
    result_who_d   = result_who;
    games_d        = games_played;
    pop            = 1'b0;
    flush          = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          state_d  = LOAD;
          shadow_d = start_seed;
          init_l_d = start_seed;
        end
      end
      LOAD: state_d = PLAY;
      PLAY: begin
        // Game end wins over a pending move; that move is dropped with the flush.
        if (GAMEOVER) begin
          flush          = 1'b1;
          result_who_d   = WHO;
          result_valid_d = 1'b1;
          games_d        = games_played + GAMES_W'(1);
          state_d        = DONE;
        end else if (count != '0) begin
          pop       = 1'b1;
          init_c_d  = 1'b0;
          control_d = head;
          shadow_d  = shadow + step_of(head);
        end
      end
      default: begin
`ifdef AUTO_RESTART_EN
        state_d  = LOAD;
        shadow_d = last_seed;
        init_l_d = last_seed;
`else
        state_d  = IDLE;
`endif
      end
    endcase

    if (flush) count_d = '0;
    else begin
      case ({push, pop})
        2'b10:   count_d = count + (AW+1)'(1);
        2'b01:   count_d = count - (AW+1)'(1);
        default: count_d = count;
      endcase
    end
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (count_d != (AW+1)'(FIFO_DEPTH)) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= cmd_op;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow       <= '0;
      last_seed    <= '0;
      INIT_c       <= 1'b1;
      INIT_l       <= '0;
      control      <= 2'b00;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_who   <= 2'b00;
      games_played <= '0;
      cmd_ready    <= 1'b1;
    end else begin
      shadow       <= shadow_d;
      if (state == IDLE && start_valid) last_seed <= start_seed;
      INIT_c       <= init_c_d;
      INIT_l       <= init_l_d;
      control      <= control_d;
      busy         <= busy_d;
      result_valid <= result_valid_d;
      result_who   <= result_who_d;
      games_played <= games_d;
      cmd_ready    <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer (default build, auto-restart off).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       start_valid;
  logic [3:0] start_seed;
  logic       INIT_c;
  logic [3:0] INIT_l;
  logic [1:0] control;
  logic       GAMEOVER;
  logic [1:0] WHO;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_who;
  logic [7:0] games_played;

  int total = 0;
  int bad   = 0;

  game_sequencer #(.SIZE(4), .FIFO_DEPTH(4), .GAMES_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .start_valid(start_valid), .start_seed(start_seed),
    .INIT_c(INIT_c), .INIT_l(INIT_l), .control(control),
    .GAMEOVER(GAMEOVER), .WHO(WHO),
    .busy(busy), .result_valid(result_valid), .result_who(result_who),
    .games_played(games_played)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; start_valid = 1'b0;
    start_seed = 4'd0; GAMEOVER = 1'b0; WHO = 2'b00;

    // reset state
    step(); step();
    chk("rst_init_c", 32'(INIT_c), 32'd1);
    chk("rst_init_l", 32'(INIT_l), 32'd0);
    chk("rst_control", 32'(control), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_games", 32'(games_played), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    reset = 1'b0;

    // start with seed 5: LOAD then PLAY hold
    start_valid = 1'b1; start_seed = 4'd5; step();
    chk("load_init_c", 32'(INIT_c), 32'd1);
    chk("load_init_l", 32'(INIT_l), 32'd5);
    chk("load_busy", 32'(busy), 32'd1);
    start_valid = 1'b0; step();
    chk("play_hold_c", 32'(INIT_c), 32'd1);
    chk("play_hold_l", 32'(INIT_l), 32'd5);

    // moves 00,01,11 back to back: 5+1+2-2 = 6
    push(2'b00);
    chk("q1_idle_c", 32'(INIT_c), 32'd1);
    push(2'b01);
    chk("mv0_c", 32'(INIT_c), 32'd0);
    chk("mv0_ctl", 32'(control), 32'd0);
    push(2'b11);
    chk("mv1_c", 32'(INIT_c), 32'd0);
    chk("mv1_ctl", 32'(control), 32'd1);
    cmd_valid = 1'b0; step();
    chk("mv2_c", 32'(INIT_c), 32'd0);
    chk("mv2_ctl", 32'(control), 32'd3);
    step();
    chk("after_c", 32'(INIT_c), 32'd1);
    chk("after_l", 32'(INIT_l), 32'd6);
    chk("after_ctl", 32'(control), 32'd3);

    // GAMEOVER with one queued move and a coinciding push: nothing issued
    push(2'b00);
    GAMEOVER = 1'b1; WHO = 2'b10; cmd_valid = 1'b1; cmd_op = 2'b01; step();
    chk("go_init_c", 32'(INIT_c), 32'd1);
    chk("go_init_l", 32'(INIT_l), 32'd6);
    chk("go_rvalid", 32'(result_valid), 32'd1);
    chk("go_who", 32'(result_who), 32'd2);
    chk("go_games", 32'(games_played), 32'd1);
    chk("go_busy", 32'(busy), 32'd1);
    chk("go_ready", 32'(cmd_ready), 32'd0);
    GAMEOVER = 1'b0; cmd_valid = 1'b0; step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rvalid", 32'(result_valid), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_who", 32'(result_who), 32'd2);

    // fill FIFO in IDLE, 5th offer refused
    push(2'b00); push(2'b11); push(2'b11);
    chk("fill3_ready", 32'(cmd_ready), 32'd1);
    push(2'b01);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    push(2'b10);
    chk("full_ready2", 32'(cmd_ready), 32'd0);
    chk("full_idle_c", 32'(INIT_c), 32'd1);
    chk("full_idle_l", 32'(INIT_l), 32'd6);
    cmd_valid = 1'b0;

    // seed 15, ops 00,11,11,01 -> 0,14,12,14
    start_valid = 1'b1; start_seed = 4'd15; step();
    chk("s15_load_l", 32'(INIT_l), 32'd15);
    start_valid = 1'b0; step();
    chk("s15_play_c", 32'(INIT_c), 32'd1);
    chk("s15_play_l", 32'(INIT_l), 32'd15);
    step();
    chk("w0_c", 32'(INIT_c), 32'd0);
    chk("w0_ctl", 32'(control), 32'd0);
    chk("w0_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("w1_ctl", 32'(control), 32'd3);
    step();
    chk("w2_ctl", 32'(control), 32'd3);
    step();
    chk("w3_c", 32'(INIT_c), 32'd0);
    chk("w3_ctl", 32'(control), 32'd1);
    step();
    chk("w_hold_c", 32'(INIT_c), 32'd1);
    chk("w_hold_l", 32'(INIT_l), 32'd14);

    // loser result, then GAMEOVER in IDLE is ignored
    GAMEOVER = 1'b1; WHO = 2'b01; step();
    chk("lose_rvalid", 32'(result_valid), 32'd1);
    chk("lose_who", 32'(result_who), 32'd1);
    chk("lose_games", 32'(games_played), 32'd2);
    GAMEOVER = 1'b0; step();
    GAMEOVER = 1'b1; step();
    chk("ign_rvalid", 32'(result_valid), 32'd0);
    chk("ign_games", 32'(games_played), 32'd2);
    chk("ign_busy", 32'(busy), 32'd0);
    GAMEOVER = 1'b0;

    // reset mid-PLAY with queued moves
    push(2'b00); push(2'b00); push(2'b00);
    cmd_valid = 1'b0;
    start_valid = 1'b1; start_seed = 4'd3; step();
    start_valid = 1'b0; step();
    chk("s3_play_l", 32'(INIT_l), 32'd3);
    step();
    chk("s3_mv_c", 32'(INIT_c), 32'd0);
    reset = 1'b1; step();
    chk("mid_rst_c", 32'(INIT_c), 32'd1);
    chk("mid_rst_l", 32'(INIT_l), 32'd0);
    chk("mid_rst_ctl", 32'(control), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_games", 32'(games_played), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_who", 32'(result_who), 32'd0);
    reset = 1'b0;
    start_valid = 1'b1; start_seed = 4'd9; step();
    start_valid = 1'b0; step(); step();
    chk("post_rst_c", 32'(INIT_c), 32'd1);
    chk("post_rst_l", 32'(INIT_l), 32'd9);
    step();
    chk("post_rst_c2", 32'(INIT_c), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
